// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter between NUM_PORTS L1 clients and a single blocking L2.
// One L2 transaction outstanding; per-port cancel suppresses the response only.
module l2_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 128
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_PORTS-1:0]        req_valid_i,
    output logic [NUM_PORTS-1:0]        req_ready_o,
    input  logic [NUM_PORTS-1:0]        req_wen_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata_i,
    input  logic [NUM_PORTS-1:0]        cancel_i,
    output logic [NUM_PORTS-1:0]        resp_valid_o,
    output logic [LINE_W-1:0]           resp_data_o,
    output logic                        l2_req_valid_o,
    input  logic                        l2_req_ready_i,
    output logic                        l2_req_wen_o,
    output logic [ADDR_W-1:0]           l2_req_addr_o,
    output logic [LINE_W-1:0]           l2_req_wdata_o,
    input  logic                        l2_resp_valid_i,
    input  logic [LINE_W-1:0]           l2_resp_data_i,
    output logic [1:0]                  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid and its fields are held until then, and ready never waits on a later valid.

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PTR_W:0] NP = (PTR_W + 1)'(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic             drop;
    logic             any_req;
    logic [PTR_W-1:0] winner;
    logic [PTR_W:0]   cand;
    logic [PTR_W:0]   owner_inc;
    logic [PTR_W-1:0] ptr_next;

    // Scan from the highest offset down so the port nearest ptr wins.
    always_comb begin
        any_req = |req_valid_i;
        winner  = ptr;
        cand    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (cand >= NP) begin
                cand = cand - NP;
            end
            if (req_valid_i[cand[PTR_W-1:0]]) begin
                winner = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        owner_inc = {1'b0, owner} + (PTR_W + 1)'(1);
        ptr_next  = owner_inc[PTR_W-1:0];
        if (owner_inc >= NP) begin
            ptr_next = '0;
        end
    end

    // Grant is combinational in IDLE and forced low while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && any_req && !rst_i) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_comb begin
        resp_valid_o = '0;
        if (state == RESP && !drop) begin
            resp_valid_o[owner] = 1'b1;
        end
    end

    assign l2_req_valid_o = (state == REQ);
    assign dbg_state_o    = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            drop           <= 1'b0;
            l2_req_wen_o   <= 1'b0;
            l2_req_addr_o  <= '0;
            l2_req_wdata_o <= '0;
            resp_data_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner          <= winner;
                        l2_req_wen_o   <= req_wen_i[winner];
                        l2_req_addr_o  <= req_addr_i[winner*ADDR_W +: ADDR_W];
                        l2_req_wdata_o <= req_wdata_i[winner*LINE_W +: LINE_W];
                        drop           <= cancel_i[winner];
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (cancel_i[owner]) begin
                        drop <= 1'b1;
                    end
                    if (l2_req_ready_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cancel_i[owner]) begin
                        drop <= 1'b1;
                    end
                    if (l2_resp_valid_i) begin
                        resp_data_o <= l2_resp_data_i;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= ptr_next;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
